// File: rtl/divisor_param_signo.sv
// Multi-cycle restoring divider, signed or unsigned per operation.
// Flags divide-by-zero and signed overflow; results held until the next request.
module divisor_param_signo #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Sgn,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               Err_div0,
  output logic               Ovf
);

  localparam int W  = tamanyo;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    FIX,
    FIN
  } st_t;

  st_t           r_st;
  logic          r_sgn;
  logic [W-1:0]  r_num;
  logic [W-1:0]  r_den;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_qs;
  logic          r_rs;
  logic          r_dz;
  logic          r_ov;

  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_dif;
  logic [W-1:0]  w_nabs;
  logic [W-1:0]  w_dabs;
  logic          w_nneg;
  logic          w_dneg;

  // One restoring step on the W+1-bit partial remainder. A magnitude of the
  // most-negative value (2^(W-1)) fits unsigned in W bits, and the shifted
  // remainder carries the extra bit so nothing overflows.
  assign w_nneg = r_sgn & r_num[W-1];
  assign w_dneg = r_sgn & r_den[W-1];
  assign w_nabs = w_nneg ? -r_num : r_num;
  assign w_dabs = w_dneg ? -r_den : r_den;
  assign w_sh   = {r_rem, r_q[W-1]};
  assign w_ge   = w_sh >= {1'b0, r_d};
  assign w_dif  = w_sh[W-1:0] - r_d;

  // Control FSM and datapath with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_st     <= IDLE;
      r_sgn    <= 1'b0;
      r_num    <= '0;
      r_den    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_qs     <= 1'b0;
      r_rs     <= 1'b0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
      Coc      <= '0;
      Res      <= '0;
      Done     <= 1'b0;
      Busy     <= 1'b0;
      Err_div0 <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (r_st)
        IDLE: begin
          // A request landing in the Done cycle is dropped.
          if (Start && !Done) begin
            r_sgn    <= Sgn;
            r_num    <= Num;
            r_den    <= Den;
            Busy     <= 1'b1;
            Err_div0 <= 1'b0;
            Ovf      <= 1'b0;
            r_st     <= PREP;
          end
        end
        PREP: begin
          r_ov <= 1'b0;
          if (r_den == '0) begin
            r_dz  <= 1'b1;
            r_q   <= '1;
            r_rem <= r_num;
            r_st  <= FIN;
          end else begin
            r_dz  <= 1'b0;
            r_q   <= w_nabs;
            r_d   <= w_dabs;
            r_rem <= '0;
            r_qs  <= w_nneg ^ w_dneg;
            r_rs  <= w_nneg;
            r_cnt <= CW'(W - 1);
            r_st  <= DIV;
          end
        end
        DIV: begin
          r_rem <= w_ge ? w_dif : w_sh[W-1:0];
          r_q   <= {r_q[W-2:0], w_ge};
          if (r_cnt == '0) begin
            r_st <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          // A positive signed quotient with the top bit set only
          // arises from most-negative / -1.
          r_ov <= r_sgn & ~r_qs & r_q[W-1];
          if (r_qs) r_q <= -r_q;
          if (r_rs) r_rem <= -r_rem;
          r_st <= FIN;
        end
        FIN: begin
          Coc      <= r_q;
          Res      <= r_rem;
          Err_div0 <= r_dz;
          Ovf      <= r_ov;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          r_st     <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_param_signo.sv
// Testbench for divisor_param_signo (tamanyo=32).
// Directed and random operations against an arithmetic reference model.
module tb_divisor_param_signo;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic         Sgn;
  logic [W-1:0] Num;
  logic [W-1:0] Den;
  logic [W-1:0] Coc;
  logic [W-1:0] Res;
  logic         Done;
  logic         Busy;
  logic         Err_div0;
  logic         Ovf;

  int tests = 0;
  int fails = 0;

  divisor_param_signo #(.tamanyo(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .Start(Start),
    .Sgn(Sgn),
    .Num(Num),
    .Den(Den),
    .Coc(Coc),
    .Res(Res),
    .Done(Done),
    .Busy(Busy),
    .Err_div0(Err_div0),
    .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         err;
    logic         ovf;
    int           lat;
  } exp_t;

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic exp_t model(input logic s, input logic [W-1:0] n,
                                 input logic [W-1:0] d);
    exp_t   e;
    longint a;
    longint b;
    longint q;
    longint r;
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 3;
    if (d == 0) begin
      e.coc = '1;
      e.res = n;
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      if (s) begin
        a = longint'($signed(n));
        b = longint'($signed(d));
      end else begin
        a = longint'({32'd0, n});
        b = longint'({32'd0, d});
      end
      q = a / b;
      r = a % b;
      e.ovf = s && (q > 64'sd2147483647);
      e.coc = q[W-1:0];
      e.res = r[W-1:0];
    end
    return e;
  endfunction

  // Issue one operation at the current negedge and check the whole
  // transaction. inj>0 pulses a rogue Start during edge k+inj;
  // poke asserts a rogue Start in the Done cycle.
  task automatic do_op(input string tag, input logic s,
                       input logic [W-1:0] n, input logic [W-1:0] d,
                       input int inj, input bit poke);
    exp_t e;
    int   j;
    int   nb;
    e = model(s, n, d);
    Start = 1'b1;
    Sgn   = s;
    Num   = n;
    Den   = d;
    @(negedge CLK);
    Start = 1'b0;
    Num   = $urandom;
    Den   = $urandom;
    Sgn   = 1'($urandom);
    j  = 0;
    nb = 0;
    while (Done !== 1'b1 && j < 100) begin
      if (Busy === 1'b1) nb++;
      if (inj > 0 && j == inj - 1) begin
        Start = 1'b1;
        Num   = 32'd1234;
        Den   = 32'd5;
      end
      if (inj > 0 && j == inj) Start = 1'b0;
      @(negedge CLK);
      j++;
    end
    chk({tag, ".lat"}, 64'(j), 64'(e.lat));
    chk({tag, ".busycyc"}, 64'(nb), 64'(e.lat));
    chk({tag, ".busy_done"}, 64'(Busy), 64'd0);
    chk({tag, ".coc"}, 64'(Coc), 64'(e.coc));
    chk({tag, ".res"}, 64'(Res), 64'(e.res));
    chk({tag, ".err"}, 64'(Err_div0), 64'(e.err));
    chk({tag, ".ovf"}, 64'(Ovf), 64'(e.ovf));
    if (poke) begin
      Start = 1'b1;
      Num   = 32'd77;
      Den   = 32'd1;
    end
    @(negedge CLK);
    Start = 1'b0;
    chk({tag, ".pulse"}, 64'(Done), 64'd0);
    chk({tag, ".hold"}, 64'(Coc), 64'(e.coc));
    if (poke) chk({tag, ".ign_done"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int  j;
    bit  saw;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    logic rs;

    RST   = 1'b1;
    Start = 1'b1;
    Sgn   = 1'b0;
    Num   = 32'd9;
    Den   = 32'd3;
    @(negedge CLK);
    chk("rst.busy", 64'(Busy), 64'd0);
    chk("rst.done", 64'(Done), 64'd0);
    chk("rst.coc", 64'(Coc), 64'd0);
    chk("rst.res", 64'(Res), 64'd0);
    chk("rst.err", 64'(Err_div0), 64'd0);
    chk("rst.ovf", 64'(Ovf), 64'd0);
    RST = 1'b0;

    do_op("u100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    do_op("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 0, 1'b0);
    do_op("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 0, 1'b0);
    do_op("u5_0", 1'b0, 32'd5, 32'd0, 0, 1'b0);
    do_op("s5_0", 1'b1, 32'd5, 32'd0, 0, 1'b0);
    do_op("sneg_0", 1'b1, 32'hFFFFFFF0, 32'd0, 0, 1'b0);
    do_op("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    do_op("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
    do_op("smin_1", 1'b1, 32'h80000000, 32'd1, 0, 1'b0);
    do_op("sexact", 1'b1, 32'hFFFFFFF4, 32'd3, 0, 1'b0);
    do_op("ubig", 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1'b0);
    do_op("inject", 1'b0, 32'd100, 32'd7, 10, 1'b1);

    Start = 1'b1;
    Sgn   = 1'b0;
    Num   = 32'd100;
    Den   = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    for (int i = 0; i < 19; i++) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort.busy", 64'(Busy), 64'd0);
    chk("abort.done", 64'(Done), 64'd0);
    chk("abort.coc", 64'(Coc), 64'd0);
    chk("abort.res", 64'(Res), 64'd0);
    chk("abort.err", 64'(Err_div0), 64'd0);
    chk("abort.ovf", 64'(Ovf), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Done === 1'b1) saw = 1'b1;
      @(negedge CLK);
    end
    chk("abort.nodone", 64'(saw), 64'd0);
    do_op("after_rst", 1'b0, 32'd9, 32'd3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      rn = $urandom;
      j  = int'($urandom_range(0, 3));
      if (j == 0) rd = 32'd0;
      else if (j == 1) rd = 32'($urandom_range(1, 20));
      else if (j == 2) rd = -32'($urandom_range(1, 20));
      else rd = $urandom;
      do_op($sformatf("rnd%0d", i), rs, rn, rd, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divisor_param_signo.md
DIVISOR_PARAM_SIGNO -- requirements
Module: divisor_param_signo

Interface
REQ-001 The block SHALL have parameter tamanyo, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, reset: synchronous, active-high.
REQ-004 The block SHALL have port Start, input, 1 bit, operation request, sampled only in IDLE.
REQ-005 The block SHALL have port Sgn, input, 1 bit: 1 = two's-complement signed operation, 0 = unsigned; sampled with Start.
REQ-006 The block SHALL have port Num, input, tamanyo bits, dividend; sampled with Start.
REQ-007 The block SHALL have port Den, input, tamanyo bits, divisor; sampled with Start.
REQ-008 The block SHALL have port Coc, output, tamanyo bits, quotient, registered.
REQ-009 The block SHALL have port Res, output, tamanyo bits, remainder, registered.
REQ-010 The block SHALL have port Done, output, 1 bit, one-cycle completion pulse, registered.
REQ-011 The block SHALL have port Busy, output, 1 bit, high while an operation is in progress.
REQ-012 The block SHALL have port Err_div0, output, 1 bit, divide-by-zero flag for the last result.
REQ-013 The block SHALL have port Ovf, output, 1 bit, signed overflow flag for the last result.

Function
REQ-014 The FSM SHALL have states IDLE, PREP, DIV, FIX, FIN.
- IDLE->PREP when Start=1.
- PREP->DIV normally; PREP->FIN when the latched Den=0.
- DIV stays for exactly tamanyo cycles (iteration counter tamanyo-1 down to 0), then ->FIX.
- FIX->FIN; FIN->IDLE unconditionally.
REQ-015 On the edge that accepts Start, the block SHALL latch Num, Den and Sgn, set Busy=1, and clear Err_div0 and Ovf.
REQ-016 In PREP, if Sgn=1 the block SHALL convert both operands to magnitudes and record the quotient sign (Num sign XOR Den sign) and the remainder sign (Num sign).
REQ-017 DIV SHALL implement restoring division producing one quotient bit per cycle, MSB first, using a tamanyo+1-bit partial remainder.
REQ-018 In FIX the block SHALL negate the quotient and remainder per their recorded signs.
- Signed quotients truncate toward zero.
- The remainder sign follows the dividend; the remainder is 0 when exact.
REQ-019 The block SHALL drive Done=1 for exactly one cycle, with Coc, Res, Err_div0 and Ovf valid in that same cycle.
REQ-020 Timing from the edge k that accepts Start:
- Normal operation: Done=1 after edge k+tamanyo+3.
- Divide-by-zero: Done=1 after edge k+2.
REQ-021 Busy SHALL be 1 from after edge k until the edge that raises Done, and 0 in the Done cycle.
REQ-022 Coc, Res, Err_div0 and Ovf SHALL hold their values from Done until the next accepted Start.
REQ-023 Start while Busy=1 or in the Done cycle SHALL be ignored, with no effect on the latched operands.
REQ-024 When Den=0, the block SHALL set Err_div0=1, Coc = all ones, Res = Num, regardless of Sgn.
REQ-025 When Sgn=1, Num = most-negative value and Den = -1, the block SHALL set Ovf=1, Coc = most-negative value (wrapped) and Res=0, and SHALL still take the full normal latency.
REQ-026 The latched magnitude of the most-negative value SHALL be handled without overflow (tamanyo+1-bit internal width).

Reset
REQ-027 With RST=1 on an edge, the block SHALL set state=IDLE and Coc=0, Res=0, Done=0, Busy=0, Err_div0=0, Ovf=0 after that edge.
REQ-028 RST asserted mid-operation SHALL abort the operation with no Done pulse.
REQ-029 RST=1 SHALL take priority over a simultaneous Start.
REQ-030 The first Start SHALL be accepted on the first edge with RST=0.

Verification (tamanyo=32)
REQ-031 Scenario: unsigned Num=100, Den=7 -> Coc=14, Res=2, Done one cycle after edge k+35, Busy high for 35 cycles.
REQ-032 Scenario: signed Num=-100 (0xFFFFFF9C), Den=7 -> Coc=0xFFFFFFF2, Res=0xFFFFFFFE; and Num=100, Den=-7 -> Coc=0xFFFFFFF2, Res=2.
REQ-033 Scenario: Num=5, Den=0 (either Sgn) -> Err_div0=1, Coc=0xFFFFFFFF, Res=5, Done after edge k+2.
REQ-034 Scenario: signed Num=0x80000000, Den=0xFFFFFFFF -> Ovf=1, Coc=0x80000000, Res=0; and unsigned Num=0xFFFFFFFF, Den=1 -> Coc=0xFFFFFFFF, Res=0, Ovf=0.
REQ-035 Scenario: Start with new operands pulsed at edge k+10 of a running operation -> ignored, the original result is returned; a Start issued one cycle after Done is accepted.
REQ-036 Scenario: RST=1 at edge k+20 -> all outputs 0, no Done pulse; the next operation 9/3 -> Coc=3, Res=0.
